axi_rdata_collector: RTL and testbench
======================================

Name: axi_rdata_collector

Overview:
- Downstream consumer of the read master's R channel.
- Accepts R beats (RID, RDATA, RRESP, RLAST) under VALID/READY and buffers them per transaction ID.
- Beats of different IDs may interleave.
- On RLAST, presents the completed burst (ID, beat count, merged response) to the device side and exposes the buffered words through a random-access read port until the device releases the burst.

Parameters:
- DATA_W, 32, RDATA and buffer word width.
- ID_W, 1, RID width; the block has 2**ID_W burst contexts.
- MAX_BEATS, 16, buffer depth per context (AXI3 ARLEN max + 1).

Ports:
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- RID  in  ID_W  read data ID.
- RDATA  in  DATA_W  read data beat.
- RRESP  in  2  beat response (0 OKAY, 1 EXOKAY, 2 SLVERR, 3 DECERR).
- RLAST  in  1  last beat of burst.
- RVALID  in  1  beat valid.
- RREADY  out  1  beat accepted when RVALID&RREADY.
- done_valid  out  1  a completed burst is available.
- done_ready  in  1  device releases the presented burst.
- done_id  out  ID_W  ID of the presented burst.
- done_len  out  4  beats received minus 1 (ARLEN encoding).
- done_resp  out  2  merged burst response.
- rd_id  in  ID_W  context select for the read port.
- rd_idx  in  4  beat index for the read port.
- rd_data  out  DATA_W  buffered word (combinational).

Behaviour:
- Reset (ARESETn=0, asynchronous):
  - All contexts EMPTY; beat counters 0; merged resp 0; overflow flags 0.
  - RREADY=0, done_valid=0, done_id=0, done_len=0, done_resp=0.
  - Buffer contents are don't-care.
- Per-context state machine: EMPTY -> FILLING on first accepted beat without RLAST; EMPTY/FILLING -> COMPLETE on accepted beat with RLAST; COMPLETE -> EMPTY on the edge where done_valid&done_ready&(done_id==ctx).
- RREADY = ARESETn-synchronised-high & (state[RID] != COMPLETE). RREADY is combinational on RID, as AXI permits, and never depends on done_ready.
- Beat accept (RVALID&RREADY):
  - If count < MAX_BEATS: buf[RID][count] <= RDATA and count increments.
  - If count == MAX_BEATS: data is discarded, count saturates, and ovf[RID] <= 1.
- Merged response: resp[RID] <= max(resp[RID], RRESP), numeric max. The first beat from EMPTY loads RRESP directly. If ovf is set, done_resp reports 2'b10 regardless.
- done_valid = any context COMPLETE. When several are complete, the lowest ID is presented (fixed priority).
  - done_id, done_len (count-1) and done_resp are driven from that context and are registered state, so they are stable while done_valid=1 and done_ready=0.
- Latency: an RLAST beat accepted at edge N gives done_valid=1 in the cycle after edge N. The context is EMPTY after the release edge, and a new beat for that ID can be accepted in the following cycle.
- Simultaneous release and new beat for the same ID: RREADY=0 that cycle, so the beat stalls one cycle. Beats for other IDs proceed in the same cycle.
- Read port: rd_data = buf[rd_id][rd_idx], combinational. The value is defined only while that context is COMPLETE and rd_idx <= done_len.
- Reset mid-burst drops all partial and completed bursts. There is no recovery of in-flight data; upstream must also be reset.

Test Plan:
- Memory bytes = address. Burst ID0, 4 beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, OKAY, RLAST on the 4th beat -> done_valid=1 one cycle after, done_id=0, done_len=3, done_resp=0; rd_idx 0..3 return those words.
- Interleave ID0 beats {0x00,0x01} with ID1 beats {0x0B0A0908, 0x0F0E0D0C, 0x13121110}, ID1 ending first -> done_id=1, done_len=2 first; after release, done_id=0 with correct data.
- Both contexts COMPLETE and done_ready held 0 for 5 cycles -> done_id=0 stable and RREADY=0 for both RID values. Pulsing done_ready presents ID1 the next cycle.
- RRESP sequence 0, 2, 0 on a 3-beat burst -> done_resp=2. Sequence 1, 1 -> done_resp=1.
- 17 beats on ID0 without RLAST, then RLAST on the 18th -> done_len=15 (0xF), done_resp=2, buf[15] holds the 16th beat.
- Release ID0 with done_ready while RVALID is high for a new ID0 beat -> RREADY=0 that cycle and the beat is accepted the next cycle. Separately, assert ARESETn=0 mid-burst -> RREADY=0 and done_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/axi_rdata_collector.sv
// R-channel collector: buffers read beats per RID, presents completed bursts
// to the device side and exposes their words through a random-access port.

module axi_rdata_ctx #(
   parameter int DATA_W    = 32,
   parameter int MAX_BEATS = 16,
   parameter int CNT_W     = 5,
   parameter int IDX_W     = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESETn,
   input  logic                              we,
   input  logic                              last,
   input  logic                              rel,
   input  logic [DATA_W-1:0]                 wdata,
   input  logic [1:0]                        wresp,
   output logic                              complete,
   output logic                              cmp_nxt,
   output logic [CNT_W-1:0]                  cnt_nxt,
   output logic [1:0]                        resp_nxt,
   output logic [MAX_BEATS-1:0][DATA_W-1:0]  words
);
   typedef enum logic [1:0] {EMPTY, FILLING, COMPLETE} ctx_st_e;
   localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_BEATS);

   ctx_st_e          st, st_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       resp, resp_n;
   logic             ovf, ovf_n;

   // Next state is exported so the top can register done_* without a cycle of lag.
   always_comb begin
      st_n   = st;
      cnt_n  = cnt;
      resp_n = resp;
      ovf_n  = ovf;
      if (rel) begin
         st_n   = EMPTY;
         cnt_n  = '0;
         resp_n = '0;
         ovf_n  = 1'b0;
      end else if (we) begin
         if (cnt < MAXC) cnt_n = cnt + 1'b1;
         else            ovf_n = 1'b1;
         if (st == EMPTY)        resp_n = wresp;
         else if (wresp > resp)  resp_n = wresp;
         st_n = last ? COMPLETE : FILLING;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         st   <= EMPTY;
         cnt  <= '0;
         resp <= '0;
         ovf  <= 1'b0;
      end else begin
         st   <= st_n;
         cnt  <= cnt_n;
         resp <= resp_n;
         ovf  <= ovf_n;
      end
   end

   always_ff @(posedge ACLK) begin
      if (we && (cnt < MAXC)) words[cnt[IDX_W-1:0]] <= wdata;
   end

   assign complete = (st == COMPLETE);
   assign cmp_nxt  = (st_n == COMPLETE);
   assign cnt_nxt  = cnt_n;
   assign resp_nxt = ovf_n ? 2'b10 : resp_n;
endmodule

module axi_rdata_collector #(
   parameter int DATA_W    = 32,
   parameter int ID_W      = 1,
   parameter int MAX_BEATS = 16
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [ID_W-1:0]   RID,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY,
   output logic              done_valid,
   input  logic              done_ready,
   output logic [ID_W-1:0]   done_id,
   output logic [3:0]        done_len,
   output logic [1:0]        done_resp,
   input  logic [ID_W-1:0]   rd_id,
   input  logic [3:0]        rd_idx,
   output logic [DATA_W-1:0] rd_data
);
   localparam int NCTX  = 1 << ID_W;
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam int IDX_W = $clog2(MAX_BEATS);

   logic [1:0]                                   rst_q;
   logic                                         acc;
   logic [NCTX-1:0]                              complete, cmp_nxt;
   logic [NCTX-1:0][CNT_W-1:0]                   cnt_nxt;
   logic [NCTX-1:0][1:0]                         resp_nxt;
   logic [NCTX-1:0][MAX_BEATS-1:0][DATA_W-1:0]   words;
   logic                                         sel_v;
   logic [ID_W-1:0]                              sel_id;
   logic [3:0]                                   sel_len;
   logic [1:0]                                   sel_resp;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) rst_q <= '0;
      else          rst_q <= {rst_q[0], 1'b1};
   end

   assign RREADY = rst_q[1] & ~complete[RID];
   assign acc    = RVALID & RREADY;

   for (genvar g = 0; g < NCTX; g++) begin : g_ctx
      axi_rdata_ctx #(
         .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W), .IDX_W(IDX_W)
      ) u_ctx (
         .ACLK     (ACLK),
         .ARESETn  (ARESETn),
         .we       (acc && (RID == ID_W'(g))),
         .last     (RLAST),
         .rel      (done_valid && done_ready && (done_id == ID_W'(g))),
         .wdata    (RDATA),
         .wresp    (RRESP),
         .complete (complete[g]),
         .cmp_nxt  (cmp_nxt[g]),
         .cnt_nxt  (cnt_nxt[g]),
         .resp_nxt (resp_nxt[g]),
         .words    (words[g])
      );
   end

   // Fixed priority: descending scan leaves the lowest complete ID selected.
   always_comb begin
      sel_v    = 1'b0;
      sel_id   = '0;
      sel_len  = '0;
      sel_resp = '0;
      for (int i = NCTX - 1; i >= 0; i--) begin
         if (cmp_nxt[i]) begin
            sel_v    = 1'b1;
            sel_id   = ID_W'(i);
            sel_len  = 4'(cnt_nxt[i] - 1'b1);
            sel_resp = resp_nxt[i];
         end
      end
   end

   // A presented burst is held until released, even if a lower ID completes meanwhile.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         done_valid <= 1'b0;
         done_id    <= '0;
         done_len   <= '0;
         done_resp  <= '0;
      end else if (!(done_valid && !done_ready)) begin
         done_valid <= sel_v;
         done_id    <= sel_id;
         done_len   <= sel_len;
         done_resp  <= sel_resp;
      end
   end

   assign rd_data = words[rd_id][rd_idx[IDX_W-1:0]];
endmodule

// File: tb/tb_axi_rdata_collector.sv
// Bench for axi_rdata_collector: directed vector table, hand-written corner
// sequences, then random traffic against a per-ID burst model.

module tb_axi_rdata_collector;
   localparam int DATA_W = 32, ID_W = 1, MAX_BEATS = 16;

   logic              ACLK = 1'b0;
   logic              ARESETn = 1'b0;
   logic [ID_W-1:0]   RID;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RLAST, RVALID, RREADY;
   logic              done_valid, done_ready;
   logic [ID_W-1:0]   done_id;
   logic [3:0]        done_len;
   logic [1:0]        done_resp;
   logic [ID_W-1:0]   rd_id;
   logic [3:0]        rd_idx;
   logic [DATA_W-1:0] rd_data;

   axi_rdata_collector #(.DATA_W(DATA_W), .ID_W(ID_W), .MAX_BEATS(MAX_BEATS)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
      .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .done_valid(done_valid),
      .done_ready(done_ready), .done_id(done_id), .done_len(done_len),
      .done_resp(done_resp), .rd_id(rd_id), .rd_idx(rd_idx), .rd_data(rd_data)
   );

   always #5 ACLK = ~ACLK;

   int n_pass = 0, n_tot = 0;

   typedef struct {
      logic            v;
      logic [ID_W-1:0] id;
      logic [31:0]     d;
      logic [1:0]      r;
      logic            l;
      logic            dr;
      logic            err;
      logic            edv;
      logic [ID_W-1:0] eid;
      logic [3:0]      elen;
      logic [1:0]      eresp;
   } vec_t;

   vec_t tbl[19];

   function automatic vec_t mk(input logic v, input logic [ID_W-1:0] id, input logic [31:0] d,
                               input logic [1:0] r, input logic l, input logic dr, input logic err,
                               input logic edv, input logic [ID_W-1:0] eid, input logic [3:0] elen,
                               input logic [1:0] eresp);
      vec_t t;
      t.v = v; t.id = id; t.d = d; t.r = r; t.l = l; t.dr = dr; t.err = err;
      t.edv = edv; t.eid = eid; t.elen = elen; t.eresp = eresp;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic idle();
      RVALID = 1'b0; RLAST = 1'b0; done_ready = 1'b0;
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) begin
         RVALID = tbl[k].v; RID = tbl[k].id; RDATA = tbl[k].d; RRESP = tbl[k].r;
         RLAST = tbl[k].l; done_ready = tbl[k].dr;
         #1 chk($sformatf("row%0d_rready", k), RREADY, tbl[k].err);
         @(posedge ACLK); #1;
         chk($sformatf("row%0d_done_valid", k), done_valid, tbl[k].edv);
         if (tbl[k].edv) begin
            chk($sformatf("row%0d_done_id", k), done_id, tbl[k].eid);
            chk($sformatf("row%0d_done_len", k), done_len, tbl[k].elen);
            chk($sformatf("row%0d_done_resp", k), done_resp, tbl[k].eresp);
         end
      end
      idle();
   endtask

   task automatic beat(input logic [ID_W-1:0] id, input logic [31:0] d, input logic [1:0] r,
                       input logic l);
      RVALID = 1'b1; RID = id; RDATA = d; RRESP = r; RLAST = l;
      #1 chk("beat_rready", RREADY, 1);
      @(posedge ACLK); #1;
      RVALID = 1'b0; RLAST = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [ID_W-1:0] id, input logic [3:0] idx,
                         input logic [31:0] exp);
      rd_id = id; rd_idx = idx;
      #1 chk(nm, rd_data, exp);
   endtask

   task automatic release_burst();
      done_ready = 1'b1;
      @(posedge ACLK); #1;
      done_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      ARESETn = 1'b0;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK) ARESETn = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;
   endtask

   // Reference model: per-ID list of stored words, beat total and merged response.
   logic [31:0] mbuf[2][16];
   int          mtot[2];
   int          mresp[2];
   bit          mcomp[2];
   bit          m_dv;
   int          m_id;

   initial begin
      tbl[0]  = mk(1, 0, 32'h03020100, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 32'h07060504, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[2]  = mk(1, 0, 32'h0B0A0908, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[3]  = mk(1, 0, 32'h0F0E0D0C, 0, 1, 0, 1, 1, 0, 3, 0);
      tbl[4]  = mk(0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 0, 32'h00000000, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[6]  = mk(1, 1, 32'h0B0A0908, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[7]  = mk(1, 1, 32'h0F0E0D0C, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[8]  = mk(1, 1, 32'h13121110, 0, 1, 0, 1, 1, 1, 2, 0);
      tbl[9]  = mk(1, 0, 32'h00000001, 0, 1, 0, 1, 1, 1, 2, 0);
      tbl[10] = mk(0, 0, 32'h0,        0, 0, 1, 0, 1, 0, 1, 0);
      tbl[11] = mk(0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 0, 0);
      tbl[12] = mk(1, 1, 32'h00000100, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[13] = mk(1, 1, 32'h00000101, 2, 0, 0, 1, 0, 0, 0, 0);
      tbl[14] = mk(1, 1, 32'h00000102, 0, 1, 0, 1, 1, 1, 2, 2);
      tbl[15] = mk(0, 1, 32'h0,        0, 0, 1, 0, 0, 0, 0, 0);
      tbl[16] = mk(1, 0, 32'h00000200, 1, 0, 0, 1, 0, 0, 0, 0);
      tbl[17] = mk(1, 0, 32'h00000201, 1, 1, 0, 1, 1, 0, 1, 1);
      tbl[18] = mk(0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 0, 0);

      idle();
      RID = '0; RDATA = '0; RRESP = '0; rd_id = '0; rd_idx = '0;
      #12;
      chk("reset_rready", RREADY, 0);
      chk("reset_done_valid", done_valid, 0);
      chk("reset_done_id", done_id, 0);
      chk("reset_done_len", done_len, 0);
      chk("reset_done_resp", done_resp, 0);
      @(negedge ACLK) ARESETn = 1'b1;
      repeat (3) @(posedge ACLK);
      #1 chk("rready_after_reset", RREADY, 1);

      // 4-beat burst, then read port
      run_rows(0, 3);
      rd_chk("burst0_w0", 0, 0, 32'h03020100);
      rd_chk("burst0_w1", 0, 1, 32'h07060504);
      rd_chk("burst0_w2", 0, 2, 32'h0B0A0908);
      rd_chk("burst0_w3", 0, 3, 32'h0F0E0D0C);
      // interleave, ID1 finishes first
      run_rows(4, 9);
      rd_chk("ilv_id1_w0", 1, 0, 32'h0B0A0908);
      rd_chk("ilv_id1_w1", 1, 1, 32'h0F0E0D0C);
      rd_chk("ilv_id1_w2", 1, 2, 32'h13121110);
      run_rows(10, 10);
      rd_chk("ilv_id0_w0", 0, 0, 32'h00000000);
      rd_chk("ilv_id0_w1", 0, 1, 32'h00000001);
      // response merge cases
      run_rows(11, 18);

      // both complete, hold done_ready low
      beat(0, 32'hAA, 0, 1);
      beat(1, 32'hBB, 0, 1);
      for (int c = 0; c < 5; c++) begin
         RVALID = 1'b1; RID = ID_W'(c % 2);
         #1 chk("hold_rready", RREADY, 0);
         chk("hold_done_valid", done_valid, 1);
         chk("hold_done_id", done_id, 0);
         @(posedge ACLK); #1;
      end
      RVALID = 1'b0;
      release_burst();
      chk("next_done_valid", done_valid, 1);
      chk("next_done_id", done_id, 1);
      rd_chk("next_id1_w0", 1, 0, 32'hBB);
      release_burst();
      chk("both_released", done_valid, 0);

      // overflow: 18 beats on ID0
      for (int i = 0; i < 18; i++) beat(0, 32'hA000 + i, 0, (i == 17));
      chk("ovf_done_valid", done_valid, 1);
      chk("ovf_done_len", done_len, 4'hF);
      chk("ovf_done_resp", done_resp, 2);
      rd_chk("ovf_w15", 0, 15, 32'hA00F);
      rd_chk("ovf_w0", 0, 0, 32'hA000);
      release_burst();

      // release and new beat for same ID in the same cycle
      beat(0, 32'h55, 0, 1);
      done_ready = 1'b1; RVALID = 1'b1; RID = 0; RDATA = 32'h66; RLAST = 1'b0; RRESP = 0;
      #1 chk("collide_rready", RREADY, 0);
      @(posedge ACLK); #1;
      done_ready = 1'b0;
      chk("collide_released", done_valid, 0);
      chk("collide_retry_rready", RREADY, 1);
      @(posedge ACLK); #1;
      RVALID = 1'b0;
      beat(0, 32'h77, 0, 1);
      chk("collide_done_len", done_len, 1);
      rd_chk("collide_w0", 0, 0, 32'h66);
      rd_chk("collide_w1", 0, 1, 32'h77);
      release_burst();

      // asynchronous reset mid-burst
      beat(1, 32'hC1, 0, 1);
      beat(0, 32'hD0, 0, 0);
      chk("prerst_done_valid", done_valid, 1);
      RVALID = 1'b1; RID = 0;
      #3 ARESETn = 1'b0;
      #1;
      chk("async_rst_rready", RREADY, 0);
      chk("async_rst_done_valid", done_valid, 0);
      idle();
      @(negedge ACLK) ARESETn = 1'b1;
      repeat (3) @(posedge ACLK);
      #1;
      chk("postrst_done_valid", done_valid, 0);
      chk("postrst_rready", RREADY, 1);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 2; i++) begin
         mtot[i] = 0; mresp[i] = 0; mcomp[i] = 0;
      end
      m_dv = 0; m_id = 0;
      for (int c = 0; c < 3000; c++) begin
         int  id, stored;
         bit  m_rr;
         RVALID     = ($urandom_range(3) != 0);
         RID        = ID_W'($urandom_range(1));
         RDATA      = $urandom;
         RRESP      = 2'($urandom_range(3));
         RLAST      = ($urandom_range(c < 1500 ? 5 : 40) == 0);
         done_ready = ($urandom_range(2) == 0);
         rd_id      = ID_W'($urandom_range(1));
         rd_idx     = 4'($urandom_range(15));
         #1;
         m_rr = !mcomp[RID];
         chk("rnd_rready", RREADY, m_rr);
         chk("rnd_done_valid", done_valid, m_dv);
         if (m_dv) begin
            stored = (mtot[m_id] > 16) ? 16 : mtot[m_id];
            chk("rnd_done_id", done_id, m_id);
            chk("rnd_done_len", done_len, stored - 1);
            chk("rnd_done_resp", done_resp, (mtot[m_id] > 16) ? 2 : mresp[m_id]);
         end
         stored = (mtot[rd_id] > 16) ? 16 : mtot[rd_id];
         if (mcomp[rd_id] && (rd_idx < stored))
            chk("rnd_rd_data", rd_data, mbuf[rd_id][rd_idx]);
         if (m_dv && done_ready) begin
            mcomp[m_id] = 0; mtot[m_id] = 0; mresp[m_id] = 0;
         end
         if (RVALID && m_rr) begin
            id = RID;
            if (mtot[id] < 16) mbuf[id][mtot[id]] = RDATA;
            mtot[id]++;
            if (mtot[id] == 1 || RRESP > mresp[id]) mresp[id] = RRESP;
            if (RLAST) mcomp[id] = 1;
         end
         if (!(m_dv && !done_ready)) begin
            m_dv = 0;
            for (int i = 1; i >= 0; i--) if (mcomp[i]) begin m_dv = 1; m_id = i; end
         end
         @(posedge ACLK); #1;
      end
      idle();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
